program_loader: RTL and testbench

//  Boot-time loader ahead of the rv32i_sc core. Takes a byte stream (host/UART side), packs it into
//  32-bit little-endian words and writes them through the write ports of the data and instruction

---
 rtl/program_loader_pkg.sv | 33 +++
 rtl/program_loader_if.sv | 17 +
 rtl/program_loader_word_packer.sv | 56 +++++
 rtl/program_loader.sv | 162 ++++++++++++++++
 tb/tb_program_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
//   Shared types and constants for the boot-time program loader.
//   - ldr_state_e : loader FSM state encoding (3 bits)
//   - ldr_hdr_t   : layout of the 32-bit stream header word
//   - is_loading  : true in the states that consume stream bytes
// ---------------------------------------------------------------------------
package program_loader_pkg;

  localparam int LDR_HDR_BYTES = 4;
  localparam int LDR_CNT_W     = 16;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_HDR   = 3'd1,
    LDR_DATA  = 3'd2,
    LDR_INSTR = 3'd3,
    LDR_RUN   = 3'd4,
    LDR_ERR   = 3'd5
  } ldr_state_e;

  // Header word after little-endian packing: D_CNT arrives first, so it
  // lands in the low half.
  typedef struct packed {
    logic [LDR_CNT_W-1:0] i_cnt;
    logic [LDR_CNT_W-1:0] d_cnt;
  } ldr_hdr_t;

  function automatic logic is_loading(input ldr_state_e st);
    return (st == LDR_HDR) || (st == LDR_DATA) || (st == LDR_INSTR);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
//   Byte-stream handshake from the host/UART side into the loader.
//   s_valid : source has a byte on s_data
//   s_data  : stream byte
//   s_ready : loader accepts the byte this cycle
//   modport master : byte source
//   modport slave  : loader
// ---------------------------------------------------------------------------
interface program_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/program_loader_word_packer.sv
// ---------------------------------------------------------------------------
// word_packer
//   Packs accepted stream bytes into little-endian words (first byte ends up
//   in bits [7:0]) and pulses word_valid for one cycle after the last byte
//   of a word has been accepted. A partial word is held across any gap.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous restart of the byte counter (new load)
//   accept      : a byte is being taken this cycle
//   byte_in     : the byte being taken
//   word_valid  : one-cycle pulse, word holds a complete word
//   word        : packed word
// ---------------------------------------------------------------------------
module word_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES);

  logic [CW-1:0]         cnt_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] sr_q;

  // NOTE: sequential state is always updated with <= so every flop samples
  // the pre-edge values and the block order inside a process does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept && (cnt_q == CW'(BYTES - 1));
      if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  // NOTE: the shift register is pure datapath and is only consumed while
  // word_valid is high, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) sr_q <= {byte_in, sr_q[DATA_WIDTH-1:8]};
  end

  assign word_valid = valid_q;
  assign word       = sr_q;

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Boot-time loader in front of the rv32i_sc core. Receives a byte stream
//   {D_CNT[15:0], I_CNT[15:0]} (both LE) followed by D_CNT data words and
//   I_CNT instruction words, writes them into the data and instruction
//   BRAMs, keeps the PC stalled and the data-BRAM port on loader control
//   until both images are in, then releases the core.
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : one-cycle pulse, begin a new load (IDLE/RUN/ERR)
//   s                     : byte stream (slave side)
//   i_w_* / d_w_*         : instruction / data BRAM write ports
//   pc_stall              : high whenever the core is not running
//   d_init_done           : data-BRAM mux select, core owns the port when 1
//   load_done             : image loaded, core running
//   load_err              : header counts exceeded BRAM capacity
// ---------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int I_WORDS    = 1024,
  parameter int D_WORDS    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  program_loader_if.slave         s,
  output logic [ADDR_WIDTH-1:0]   i_w_addr,
  output logic [DATA_WIDTH-1:0]   i_w_dat,
  output logic                    i_w_enb,
  output logic [DATA_WIDTH/8-1:0] i_w_byte_enb,
  output logic [ADDR_WIDTH-1:0]   d_w_addr,
  output logic [DATA_WIDTH-1:0]   d_w_dat,
  output logic                    d_w_enb,
  output logic [DATA_WIDTH/8-1:0] d_w_byte_enb,
  output logic                    pc_stall,
  output logic                    d_init_done,
  output logic                    load_done,
  output logic                    load_err
);

  ldr_state_e           state_q, state_d;
  logic [LDR_CNT_W-1:0] idx_q, idx_d;
  logic [LDR_CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic [LDR_CNT_W-1:0] i_cnt_q, i_cnt_d;

  logic                  accept;
  logic                  clear;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;
  ldr_hdr_t              hdr;
  logic [ADDR_WIDTH-1:0] word_addr;

  // Writes happen in the word_valid cycle, so the stream is held off then.
  assign s.s_ready = is_loading(state_q) && !word_valid;
  assign accept    = s.s_valid && s.s_ready;
  assign hdr       = ldr_hdr_t'(word[31:0]);
  assign word_addr = ADDR_WIDTH'({idx_q, 2'b00});

  word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .byte_in    (s.s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LDR_IDLE;
      idx_q   <= '0;
      d_cnt_q <= '0;
      i_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_cnt_q <= d_cnt_d;
      i_cnt_q <= i_cnt_d;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_cnt_d = d_cnt_q;
    i_cnt_d = i_cnt_q;
    clear   = 1'b0;

    unique case (state_q)
      LDR_IDLE, LDR_RUN, LDR_ERR: begin
        if (start) begin
          state_d = LDR_HDR;
          idx_d   = '0;
          clear   = 1'b1;
        end
      end

      LDR_HDR: begin
        if (word_valid) begin
          d_cnt_d = hdr.d_cnt;
          i_cnt_d = hdr.i_cnt;
          idx_d   = '0;
          if (int'(hdr.d_cnt) > D_WORDS || int'(hdr.i_cnt) > I_WORDS)
            state_d = LDR_ERR;
          else if (hdr.d_cnt != '0)
            state_d = LDR_DATA;
          else if (hdr.i_cnt != '0)
            state_d = LDR_INSTR;
          else
            state_d = LDR_RUN;
        end
      end

      LDR_DATA: begin
        if (word_valid) begin
          if (idx_q == d_cnt_q - 1'b1) begin
            idx_d   = '0;
            state_d = (i_cnt_q == '0) ? LDR_RUN : LDR_INSTR;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      LDR_INSTR: begin
        if (word_valid) begin
          if (idx_q == i_cnt_q - 1'b1) begin
            idx_d   = '0;
            state_d = LDR_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = LDR_IDLE;
    endcase
  end

  // Write ports are driven only in the strobe cycle and read as zero
  // otherwise, which also gives the all-zero reset values.
  assign d_w_enb      = (state_q == LDR_DATA) && word_valid;
  assign d_w_addr     = d_w_enb ? word_addr : '0;
  assign d_w_dat      = d_w_enb ? word : '0;
  assign d_w_byte_enb = {(DATA_WIDTH/8){d_w_enb}};

  assign i_w_enb      = (state_q == LDR_INSTR) && word_valid;
  assign i_w_addr     = i_w_enb ? word_addr : '0;
  assign i_w_dat      = i_w_enb ? word : '0;
  assign i_w_byte_enb = {(DATA_WIDTH/8){i_w_enb}};

  assign pc_stall    = (state_q != LDR_RUN);
  assign d_init_done = (state_q == LDR_RUN);
  assign load_done   = (state_q == LDR_RUN);
  assign load_err    = (state_q == LDR_ERR);

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//   Directed bench for program_loader: full load, empty data section,
//   capacity errors, empty image, random stream gaps, reset mid-load.
// ---------------------------------------------------------------------------
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb;
  logic [3:0]  i_w_byte_enb, d_w_byte_enb;
  logic        pc_stall, d_init_done, load_done, load_err;

  program_loader_if s();

  program_loader #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .I_WORDS(1024), .D_WORDS(1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s            (s),
    .i_w_addr     (i_w_addr),
    .i_w_dat      (i_w_dat),
    .i_w_enb      (i_w_enb),
    .i_w_byte_enb (i_w_byte_enb),
    .d_w_addr     (d_w_addr),
    .d_w_dat      (d_w_dat),
    .d_w_enb      (d_w_enb),
    .d_w_byte_enb (d_w_byte_enb),
    .pc_stall     (pc_stall),
    .d_init_done  (d_init_done),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_d [2] = '{32'h1122_3344, 32'h5566_7788};
  logic [31:0] exp_i [3] = '{32'h0050_0293, 32'h0010_0313, 32'h0000_006f};
  logic [43:0] d_log [$];
  logic [43:0] i_log [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write monitor: records every strobe and checks the per-write rules.
  always @(negedge clk) begin
    if (!rst && (i_w_enb || d_w_enb)) begin
      check("wr_s_ready_low", s.s_ready, 1'b0);
      check("wr_one_port", i_w_enb & d_w_enb, 1'b0);
      if (i_w_enb) begin
        check("i_byte_enb", i_w_byte_enb, 4'hf);
        i_log.push_back({i_w_addr, i_w_dat});
      end
      if (d_w_enb) begin
        check("d_byte_enb", d_w_byte_enb, 4'hf);
        d_log.push_back({d_w_addr, d_w_dat});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_stall"},    pc_stall,     1'b1);
    check({tag, "_s_ready"},     s.s_ready,    1'b0);
    check({tag, "_i_w_enb"},     i_w_enb,      1'b0);
    check({tag, "_d_w_enb"},     d_w_enb,      1'b0);
    check({tag, "_i_w_addr"},    i_w_addr,     12'h0);
    check({tag, "_d_w_addr"},    d_w_addr,     12'h0);
    check({tag, "_i_w_dat"},     i_w_dat,      32'h0);
    check({tag, "_d_w_dat"},     d_w_dat,      32'h0);
    check({tag, "_i_byte_enb"},  i_w_byte_enb, 4'h0);
    check({tag, "_d_byte_enb"},  d_w_byte_enb, 4'h0);
    check({tag, "_d_init_done"}, d_init_done,  1'b0);
    check({tag, "_load_done"},   load_done,    1'b0);
    check({tag, "_load_err"},    load_err,     1'b0);
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that took the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    s.s_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    s.s_valid = 1'b1;
    s.s_data  = b;
    @(negedge clk);
    while (!s.s_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("byte_accept", s.s_ready, 1'b1);
    @(posedge clk);
    #1;
    s.s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], int'($urandom_range(max_gap, 0)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_logs();
    d_log.delete();
    i_log.delete();
  endtask

  // Header D=2,I=3 plus both images, ending with the post-load checks.
  task automatic run_case1(input string tag, input int max_gap, input logic poke_start);
    send_word(32'h0003_0002, max_gap);
    send_word(exp_d[0], max_gap);
    if (poke_start) pulse_start();
    send_word(exp_d[1], max_gap);
    for (int k = 0; k < 3; k++) send_word(exp_i[k], max_gap);
    // Cycle of the final instruction write strobe.
    @(negedge clk);
    check({tag, "_last_i_enb"},   i_w_enb,   1'b1);
    check({tag, "_last_i_addr"},  i_w_addr,  12'h008);
    check({tag, "_last_stall"},   pc_stall,  1'b1);
    check({tag, "_last_done"},    load_done, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_run_stall"},    pc_stall,     1'b0);
    check({tag, "_run_done"},     load_done,    1'b1);
    check({tag, "_run_dinit"},    d_init_done,  1'b1);
    check({tag, "_run_i_enb"},    i_w_enb,      1'b0);
    check({tag, "_run_byte_enb"}, i_w_byte_enb, 4'h0);
    check({tag, "_run_ready"},    s.s_ready,    1'b0);
    check({tag, "_d_count"}, d_log.size(), 2);
    check({tag, "_i_count"}, i_log.size(), 3);
    for (int k = 0; k < 2 && k < d_log.size(); k++)
      check({tag, "_d_write"}, d_log[k], {12'(k * 4), exp_d[k]});
    for (int k = 0; k < 3 && k < i_log.size(); k++)
      check({tag, "_i_write"}, i_log[k], {12'(k * 4), exp_i[k]});
  endtask

  initial begin
    s.s_valid = 1'b0;
    s.s_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in_rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Case 1: D=2, I=3, no gaps, start pulse in DATA must be ignored
    pulse_start();
    @(negedge clk);
    check("hdr_ready", s.s_ready, 1'b1);
    check("hdr_stall", pc_stall, 1'b1);
    @(posedge clk);
    #1;
    run_case1("c1", 0, 1'b1);

    // Case 2: D=0, I=1, restart from RUN
    clear_logs();
    pulse_start();
    @(negedge clk);
    check("c2_restall", pc_stall, 1'b1);
    check("c2_undone",  load_done, 1'b0);
    @(posedge clk);
    #1;
    send_word(32'h0001_0000, 0);
    send_word(32'h0000_0013, 0);
    @(negedge clk);
    check("c2_i_enb",  i_w_enb,  1'b1);
    check("c2_i_addr", i_w_addr, 12'h000);
    check("c2_i_dat",  i_w_dat,  32'h0000_0013);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("c2_done",    load_done,    1'b1);
    check("c2_d_count", d_log.size(), 0);
    check("c2_i_count", i_log.size(), 1);

    // Case 3: I_CNT=0x0401 exceeds capacity
    clear_logs();
    pulse_start();
    send_word(32'h0401_0000, 0);
    @(negedge clk);
    check("c3_hdr_no_err", load_err, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("c3_err",   load_err,  1'b1);
    check("c3_stall", pc_stall,  1'b1);
    check("c3_ready", s.s_ready, 1'b0);
    check("c3_done",  load_done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("c3_no_writes", d_log.size() + i_log.size(), 0);
    pulse_start();
    @(negedge clk);
    check("c3_restart_err",   load_err,  1'b0);
    check("c3_restart_ready", s.s_ready, 1'b1);
    @(posedge clk);
    #1;

    // D_CNT=0x0401 also exceeds capacity
    send_word(32'h0000_0401, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("c3d_err", load_err, 1'b1);

    // Empty image: D=0, I=0 goes straight to RUN
    pulse_start();
    send_word(32'h0000_0000, 0);
    @(negedge clk);
    check("empty_stall_hdr", pc_stall, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("empty_done",   load_done, 1'b1);
    check("empty_stall",  pc_stall,  1'b0);
    check("empty_writes", d_log.size() + i_log.size(), 0);

    // Case 4: case 1 with random s_valid gaps of 0-7 clocks
    clear_logs();
    pulse_start();
    run_case1("c4", 7, 1'b0);

    // Case 5: reset after the 6th data byte, then a clean reload
    clear_logs();
    pulse_start();
    send_word(32'h0003_0002, 0);
    send_word(exp_d[0], 0);
    send_byte(exp_d[1][7:0], 0);
    send_byte(exp_d[1][15:8], 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    clear_logs();
    pulse_start();
    run_case1("c5", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
